// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered (non-FWFT) read data,
//            full/empty/almost-full flags, occupancy count and one-cycle
//            overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_LVL = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_depth  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_af_lvl = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_WIDTH:0] c_ptr_one = (ADDR_WIDTH + 1)'(1);

    // Storage is intentionally not reset; the pointers alone define validity.
    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    // Flags and count derive only from the registered pointers.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                      (r_wr_ptr[ADDR_WIDTH]     != r_rd_ptr[ADDR_WIDTH]);
    assign w_count  = r_wr_ptr - r_rd_ptr;

    // A write into a full FIFO is still taken when a read frees a slot
    // in the same cycle.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    assign empty       = w_empty;
    assign full        = w_full;
    assign count       = w_count;
    assign almost_full = (w_count >= c_af_lvl);
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // Storage write; requests are ignored while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Write pointer advances on every accepted write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
    end

    // Read pointer, registered read word and its valid strobe. A read of
    // the slot being rewritten in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Single-cycle error pulses for rejected requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en & ~w_wr_acc;
            r_underflow <= rd_en & w_empty;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Directed self-checking bench for sync_fifo with a queue-based
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    sync_fifo #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .ALMOST_FULL_LVL(12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .almost_full(almost_full),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the acceptance rules applied.
    logic [7:0] m_q[$];
    logic       m_init = 1'b0;
    logic       m_rd_valid, m_ovf, m_unf;
    logic [7:0] m_rd_data;

    always @(posedge clk) begin
        bit was_empty, was_full, racc, wacc;
        if (!rst_n) begin
            m_q.delete();
            m_rd_valid = 1'b0;
            m_rd_data  = 8'h00;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_init     = 1'b1;
        end else if (m_init) begin
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == 16);
            racc = rd_en && !was_empty;
            wacc = wr_en && (!was_full || racc);
            if (racc) m_rd_data = m_q.pop_front();
            m_rd_valid = racc;
            if (wacc) m_q.push_back(wr_data);
            m_ovf = wr_en && !wacc;
            m_unf = rd_en && was_empty;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("cyc_count",    32'(count),       32'(m_q.size()));
            check("cyc_empty",    32'(empty),       32'(m_q.size() == 0));
            check("cyc_full",     32'(full),        32'(m_q.size() == 16));
            check("cyc_afull",    32'(almost_full), 32'(m_q.size() >= 12));
            check("cyc_rd_valid", 32'(rd_valid),    32'(m_rd_valid));
            check("cyc_rd_data",  32'(rd_data),     32'(m_rd_data));
            check("cyc_overflow", 32'(overflow),    32'(m_ovf));
            check("cyc_underflow",32'(underflow),   32'(m_unf));
        end
    end

    // Apply inputs, then advance past the next rising edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        @(posedge clk); #1;

        // Reset then idle
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_ovf",   32'(overflow), 0);
        check("rst_unf",   32'(underflow), 0);

        // Fill with 0x0F..0x1E
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(8'h0F + i), 0);
            if (i == 10) check("afull_at11", 32'(almost_full), 0);
            if (i == 11) check("afull_at12", 32'(almost_full), 1);
        end
        check("fill_full",  32'(full), 1);
        check("fill_count", 32'(count), 16);

        // Overflow: 0x1F dropped
        cyc(1, 8'h1F, 0);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        cyc(0, 8'h00, 0);
        check("ovf_clear", 32'(overflow), 0);

        // Drain: 0x0F..0x1E in order
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1);
            check("drain_valid", 32'(rd_valid), 1);
            check("drain_data",  32'(rd_data), 32'(8'h0F + i));
        end
        cyc(0, 8'h00, 0);
        check("drain_empty", 32'(empty), 1);
        check("drain_novalid", 32'(rd_valid), 0);
        check("drain_hold", 32'(rd_data), 32'h1E);

        // Underflow
        cyc(0, 8'h00, 1);
        check("unf_pulse", 32'(underflow), 1);
        check("unf_valid", 32'(rd_valid), 0);
        cyc(0, 8'h00, 0);
        check("unf_clear", 32'(underflow), 0);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
        cyc(1, 8'hAA, 1);
        check("rw_full_data",  32'(rd_data), 32'h00);
        check("rw_full_count", 32'(count), 16);
        check("rw_full_ovf",   32'(overflow), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 8'h00, 1);
            check("rw_full_drain", 32'(rd_data), (i == 16) ? 32'hAA : 32'(i));
        end

        // Simultaneous read/write while empty
        cyc(1, 8'h55, 1);
        check("rw_empty_unf",   32'(underflow), 1);
        check("rw_empty_count", 32'(count), 1);
        check("rw_empty_empty", 32'(empty), 0);
        cyc(0, 8'h00, 1);
        check("rw_empty_data", 32'(rd_data), 32'h55);

        // Wrap: 40-word ramp with 3-word lead, read every cycle after lead
        begin
            logic [7:0] exp_v;
            exp_v = 8'h80;
            cyc(0, 8'h00, 0);
            for (int i = 0; i < 3; i++) cyc(1, 8'(8'h80 + i), 0);
            for (int i = 3; i < 43; i++) begin
                cyc(i < 40, 8'(8'h80 + i), 1);
                check("wrap_valid", 32'(rd_valid), 1);
                check("wrap_data",  32'(rd_data), 32'(exp_v));
                exp_v = exp_v + 8'h01;
                if (i < 40) check("wrap_count", 32'(count == 5'd3 || count == 5'd4), 1);
            end
            check("wrap_end_empty", 32'(empty), 1);
        end

        // Mid-operation reset
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h30 + i), 0);
        check("pre_rst_count", 32'(count), 9);
        rst_n = 1'b0;
        cyc(1, 8'hEE, 1);
        rst_n = 1'b1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_valid", 32'(rd_valid), 0);
        cyc(1, 8'hC0, 0);
        cyc(1, 8'hC1, 0);
        cyc(0, 8'h00, 1);
        check("post_rst_d0", 32'(rd_data), 32'hC0);
        cyc(0, 8'h00, 1);
        check("post_rst_d1", 32'(rd_data), 32'hC1);
        cyc(0, 8'h00, 0);
        check("post_rst_empty", 32'(empty), 1);

        cyc(0, 8'h00, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
